alu_op_encoder: RTL and testbench

- Inverse of the ALU control decode: turns a requested 3-bit ALU control code plus register fields into a 32-bit MIPS R-type instruction word.
- Each word is tagged with a sequential instruction-memory byte address.
- Sits between the bench/loader side and instruction memory. Used to preload programs and to close the loop with the funct-to-ALU-control decode.
- Requests arrive on a valid/ready handshake. Words leave through a 2-entry output FIFO on a second valid/ready handshake.

---
 rtl/alu_op_encoder.sv | 165 ++++++++++++++++
 tb/tb_alu_op_encoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_encoder.sv
// Turns a requested ALU control code plus register fields into a MIPS R-type word,
// tags it with a sequential byte address and queues it in a 2-entry output FIFO.
module alu_op_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_alu_ctrl,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    logic              w_supported;
    logic [5:0]        w_funct;
    logic [31:0]       w_word;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_slot_full;
    logic [1:0]        w_slot_full_next;
    logic [1:0]        w_push_slot;
    logic [1:0]        w_pop_slot;
    logic [31:0]       w_slot_instr [2];
    logic [ADDR_W-1:0] w_slot_addr  [2];
    logic              w_head_next;
    logic [31:0]       w_head_instr_next;
    logic [ADDR_W-1:0] w_head_addr_next;

    logic              r_head;
    logic              r_tail;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic              r_err_pulse;
    logic [7:0]        r_err_count;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;

    // Inverse of the funct-to-ALU-control decode; anything else is rejected.
    always_comb begin
        w_supported = 1'b1;
        w_funct     = 6'b000000;
        case (req_alu_ctrl)
            3'b010:  w_funct = 6'b100000;
            3'b110:  w_funct = 6'b100010;
            3'b000:  w_funct = 6'b100100;
            3'b001:  w_funct = 6'b100101;
            3'b111:  w_funct = 6'b101010;
            default: w_supported = 1'b0;
        endcase
    end

    assign w_word    = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, w_funct};

    // Ready comes only from stored occupancy, so a stalled consumer never forms a comb path.
    assign req_ready = ~(w_slot_full[0] & w_slot_full[1]);
    assign out_valid = w_slot_full[0] | w_slot_full[1];

    assign w_accept  = req_valid & req_ready;
    assign w_push    = w_accept & w_supported;
    assign w_pop     = out_valid & out_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            slot_state_t       r_state;
            slot_state_t       w_state_next;
            logic [31:0]       r_instr;
            logic [ADDR_W-1:0] r_addr;

            assign w_push_slot[gi] = w_push & (r_tail == 1'(gi));
            assign w_pop_slot[gi]  = w_pop  & (r_head == 1'(gi));

            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    SLOT_EMPTY: if (w_push_slot[gi]) w_state_next = SLOT_FULL;
                    SLOT_FULL:  if (w_pop_slot[gi])  w_state_next = SLOT_EMPTY;
                    default:    w_state_next = SLOT_EMPTY;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= SLOT_EMPTY;
                    r_instr <= '0;
                    r_addr  <= '0;
                end else begin
                    r_state <= w_state_next;
                    if (w_push_slot[gi]) begin
                        r_instr <= w_word;
                        r_addr  <= r_addr_cnt;
                    end
                end
            end

            assign w_slot_full[gi]      = (r_state == SLOT_FULL);
            assign w_slot_full_next[gi] = (w_state_next == SLOT_FULL);
            assign w_slot_instr[gi]     = r_instr;
            assign w_slot_addr[gi]      = r_addr;
        end
    endgenerate

    // Look ahead to the entry that will sit at the head after this edge, so the
    // registered output shows it next cycle and simply holds once the FIFO drains.
    always_comb begin
        w_head_next = r_head ^ w_pop;
        if (w_push_slot[w_head_next]) begin
            w_head_instr_next = w_word;
            w_head_addr_next  = r_addr_cnt;
        end else begin
            w_head_instr_next = w_slot_instr[w_head_next];
            w_head_addr_next  = w_slot_addr[w_head_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_addr_cnt  <= BASE;
            r_err_pulse <= 1'b0;
            r_err_count <= 8'd0;
            r_out_instr <= 32'd0;
            r_out_addr  <= '0;
        end else begin
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push) begin
                r_tail     <= ~r_tail;
                r_addr_cnt <= r_addr_cnt + ADDR_STEP;
            end
            r_err_pulse <= w_accept & ~w_supported;
            if (w_accept && !w_supported && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (w_slot_full_next[w_head_next]) begin
                r_out_instr <= w_head_instr_next;
                r_out_addr  <= w_head_addr_next;
            end
        end
    end

    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Bench for alu_op_encoder: a reference queue tracks the expected FIFO contents,
// error counter and output hold values, checked every cycle on the falling edge.
module tb_alu_op_encoder;

    localparam logic [9:0] BASE = 10'h000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_alu_ctrl;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        err_pulse;
    logic [7:0]  err_count;

    alu_op_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_alu_ctrl (req_alu_ctrl),
        .req_rs       (req_rs),
        .req_rt       (req_rt),
        .req_rd       (req_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_addr     (out_addr),
        .err_pulse    (err_pulse),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  code;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] exp_instr;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  addr;
        logic [2:0]  code;
    } sb_t;

    sb_t         sb_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] cur_exp;
    logic        acc_flag;
    logic [9:0]  m_addr;
    logic [7:0]  m_err_cnt;
    logic        m_pulse;
    logic [31:0] last_instr;
    logic [9:0]  last_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 60)
                $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] c, input logic [4:0] s,
                                        input logic [4:0] t, input logic [4:0] d);
        logic [5:0] f;
        f = 6'h00;
        case (c)
            3'b010:  f = 6'h20;
            3'b110:  f = 6'h22;
            3'b000:  f = 6'h24;
            3'b001:  f = 6'h25;
            3'b111:  f = 6'h2A;
            default: f = 6'h00;
        endcase
        return {6'b000000, s, t, d, 5'b00000, f};
    endfunction

    function automatic logic is_sup(input logic [2:0] c);
        return (c == 3'b010) || (c == 3'b110) || (c == 3'b000) || (c == 3'b001) || (c == 3'b111);
    endfunction

    function automatic logic [2:0] dec(input logic [5:0] f);
        return {f[1], ~f[2] | f[3], (f[3] & f[1]) | f[0]};
    endfunction

    // Reference model and scoreboard, evaluated half a cycle before each active edge.
    always @(negedge clk) begin
        logic ready_m;
        sb_t  e;
        if (!rst_n) begin
            sb_q.delete();
            m_addr     = BASE;
            m_err_cnt  = 8'd0;
            m_pulse    = 1'b0;
            last_instr = 32'd0;
            last_addr  = 10'd0;
            acc_flag   = 1'b0;
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
            chk("rst_err_count", {24'd0, err_count}, 32'd0);
            chk("rst_out_instr", out_instr, 32'd0);
        end else begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() > 0});
            chk("req_ready", {31'd0, req_ready}, {31'd0, sb_q.size() < 2});
            chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
            chk("err_count", {24'd0, err_count}, {24'd0, m_err_cnt});
            if (sb_q.size() > 0) begin
                chk("head_instr", out_instr, sb_q[0].instr);
                chk("head_addr", {22'd0, out_addr}, {22'd0, sb_q[0].addr});
            end else begin
                chk("hold_instr", out_instr, last_instr);
                chk("hold_addr", {22'd0, out_addr}, {22'd0, last_addr});
            end
            ready_m = (sb_q.size() < 2);
            if (sb_q.size() > 0 && out_ready) begin
                e = sb_q.pop_front();
                chk("roundtrip", {29'd0, dec(out_instr[5:0])}, {29'd0, e.code});
                last_instr = e.instr;
                last_addr  = e.addr;
            end
            acc_flag = req_valid && ready_m;
            m_pulse  = 1'b0;
            if (acc_flag) begin
                if (is_sup(req_alu_ctrl)) begin
                    sb_q.push_back('{instr: cur_exp, addr: m_addr, code: req_alu_ctrl});
                    m_addr = m_addr + 10'd4;
                end else begin
                    m_pulse = 1'b1;
                    if (m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
                end
            end
        end
    end

    task automatic wait_accept();
        logic got;
        got = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(posedge clk);
            if (acc_flag) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        req_valid = 1'b0;
        chk("accept_within_budget", {31'd0, got}, 32'd1);
    endtask

    task automatic present(input logic [2:0] c, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [31:0] e);
        req_alu_ctrl = c;
        req_rs       = s;
        req_rt       = t;
        req_rd       = d;
        cur_exp      = e;
        req_valid    = 1'b1;
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [31:0] e);
        present(c, s, t, d, e);
        wait_accept();
        $display("req code=%03b rs=%0d rt=%0d rd=%0d exp=0x%08h", c, s, t, d, e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t        vec [6];
    logic [2:0]  codes [5];
    logic [2:0]  c;
    logic [4:0]  s, t, d;

    initial begin
        vec[0] = '{3'b110, 5'd1, 5'd2, 5'd3, 32'h0022_1822};
        vec[1] = '{3'b010, 5'd4, 5'd5, 5'd6, 32'h0085_3020};
        vec[2] = '{3'b110, 5'd4, 5'd5, 5'd6, 32'h0085_3022};
        vec[3] = '{3'b000, 5'd4, 5'd5, 5'd6, 32'h0085_3024};
        vec[4] = '{3'b001, 5'd4, 5'd5, 5'd6, 32'h0085_3025};
        vec[5] = '{3'b111, 5'd4, 5'd5, 5'd6, 32'h0085_302A};
        codes  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

        rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b0; cur_exp = 32'd0;
        req_alu_ctrl = 3'd0; req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0;
        wait_cycles(3);
        rst_n = 1'b1;

        // Single request: one-cycle latency, then empty again.
        out_ready = 1'b1;
        send(vec[0].code, vec[0].rs, vec[0].rt, vec[0].rd, vec[0].exp_instr);
        @(negedge clk);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_instr", out_instr, 32'h0022_1822);
        chk("t1_addr", {22'd0, out_addr}, 32'h000);
        @(negedge clk);
        chk("t1_empty", {31'd0, out_valid}, 32'd0);
        wait_cycles(1);

        // Every supported code back to back.
        for (int i = 1; i < 6; i++)
            send(vec[i].code, vec[i].rs, vec[i].rt, vec[i].rd, vec[i].exp_instr);
        wait_cycles(3);

        // Stalled consumer: two accepted, the third waits until the FIFO drains.
        out_ready = 1'b0;
        send(vec[1].code, vec[1].rs, vec[1].rt, vec[1].rd, vec[1].exp_instr);
        send(vec[2].code, vec[2].rs, vec[2].rt, vec[2].rd, vec[2].exp_instr);
        present(vec[3].code, vec[3].rs, vec[3].rt, vec[3].rd, vec[3].exp_instr);
        repeat (3) begin
            @(negedge clk);
            chk("t3_full_ready", {31'd0, req_ready}, 32'd0);
            chk("t3_hold_first", out_instr, vec[1].exp_instr);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        wait_cycles(3);

        // Unsupported code: consumed, flagged, address not advanced.
        send(3'b101, 5'd7, 5'd8, 5'd9, 32'd0);
        @(negedge clk);
        chk("t4_pulse", {31'd0, err_pulse}, 32'd1);
        chk("t4_count", {24'd0, err_count}, 32'd1);
        chk("t4_no_word", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("t4_pulse_end", {31'd0, err_pulse}, 32'd0);
        @(posedge clk); #1;
        send(vec[0].code, vec[0].rs, vec[0].rt, vec[0].rd, vec[0].exp_instr);
        wait_cycles(2);
        chk("t4_reused_addr", {22'd0, out_addr}, 32'h024);

        // Error counter saturation.
        for (int i = 0; i < 256; i++)
            send(3'b100, 5'(i), 5'd0, 5'd0, 32'd0);
        wait_cycles(2);
        chk("t5_saturated", {24'd0, err_count}, 32'd255);

        // Fresh start, then walk the address counter all the way round.
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            c = codes[$urandom_range(0, 4)];
            s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
            send(c, s, t, d, enc(c, s, t, d));
        end
        wait_cycles(3);
        chk("t6_last_addr", {22'd0, out_addr}, 32'h3FC);
        send(vec[5].code, vec[5].rs, vec[5].rt, vec[5].rd, vec[5].exp_instr);
        wait_cycles(2);
        chk("t6_wrap_addr", {22'd0, out_addr}, 32'h000);

        // Reset with two words queued discards them at once.
        out_ready = 1'b0;
        send(vec[1].code, vec[1].rs, vec[1].rt, vec[1].rd, vec[1].exp_instr);
        send(vec[2].code, vec[2].rs, vec[2].rt, vec[2].rd, vec[2].exp_instr);
        wait_cycles(1);
        rst_n = 1'b0;
        #1;
        chk("t7_async_clear", {31'd0, out_valid}, 32'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(vec[4].code, vec[4].rs, vec[4].rt, vec[4].rd, vec[4].exp_instr);
        @(negedge clk);
        chk("t7_base_addr", {22'd0, out_addr}, {22'd0, BASE});
        chk("t7_valid", {31'd0, out_valid}, 32'd1);
        wait_cycles(4);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
